// File: rtl/hssl_tx_link_driver.sv
// hssl_tx_link_driver
// Transmit-side link driver for the spiNNlink HSSL. After reset or a restart
// request it holds the transceiver electrically idle, then streams comma
// alignment words, then forwards 32-bit frame words. In the run state it
// fills idle slots with commas and forces a comma after COMMA_PERIOD
// consecutive frame words so the far receiver keeps its alignment.
// Optional feature macro: HSSL_TX_FRAME_CNT_EN adds frames_sent_out, a
// wrapping count of accepted frame words that only reset clears.

module hssl_tx_link_driver #(
  parameter int          NUM_CLKC_FOR_IDLE  = 1000,
  parameter int          NUM_CLKC_FOR_ALIGN = 64,
  parameter int          COMMA_PERIOD       = 16,
  parameter logic [31:0] COMMA_DATA         = 32'hB5B5_B5BC,
  parameter logic [3:0]  COMMA_KCHR         = 4'b0001
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        restart_in,
  input  logic [31:0] frm_data_in,
  input  logic [3:0]  frm_kchr_in,
  input  logic        frm_vld_in,
  output logic        frm_rdy_out,
  output logic [31:0] tx_data_out,
  output logic [3:0]  tx_charisk_out,
  output logic        tx_elecidle_out,
`ifdef HSSL_TX_FRAME_CNT_EN
  output logic [31:0] frames_sent_out,
`endif
  output logic [1:0]  link_state_out
);

  localparam int              RUN_W      = $clog2(COMMA_PERIOD + 1);
  localparam logic [9:0]      IDLE_LOAD  = 10'(NUM_CLKC_FOR_IDLE);
  localparam logic [7:0]      ALIGN_LAST = 8'(NUM_CLKC_FOR_ALIGN - 1);
  localparam logic [RUN_W-1:0] RUN_MAX   = RUN_W'(COMMA_PERIOD);

  typedef enum logic [1:0] {
    RUN_ST   = 2'b00,
    ALIGN_ST = 2'b01,
    IDLE_ST  = 2'b10
  } state_e;

  state_e           state_q, state_d;
  logic [9:0]       idle_cnt_q, idle_cnt_d;
  logic [7:0]       align_cnt_q, align_cnt_d;
  logic [RUN_W-1:0] run_cnt_q, run_cnt_d;
  logic [31:0]      tx_data_q, tx_data_d;
  logic [3:0]       tx_kchr_q, tx_kchr_d;
  logic             elecidle_q, elecidle_d;
  logic             xfer;

  // Ready only in run, never during a restart request, and not once a full
  // burst of frame words has gone out (that slot carries the forced comma).
  assign frm_rdy_out = (state_q == RUN_ST) && !restart_in && (run_cnt_q < RUN_MAX);
  assign xfer        = frm_vld_in && frm_rdy_out;

  assign tx_data_out     = tx_data_q;
  assign tx_charisk_out  = tx_kchr_q;
  assign tx_elecidle_out = elecidle_q;
  assign link_state_out  = state_q;

  // Next-state logic: idle countdown, align count, run burst tracking.
  always_comb begin
    state_d     = state_q;
    idle_cnt_d  = idle_cnt_q;
    align_cnt_d = align_cnt_q;
    run_cnt_d   = run_cnt_q;
    tx_data_d   = COMMA_DATA;
    tx_kchr_d   = COMMA_KCHR;
    elecidle_d  = elecidle_q;
    if (restart_in) begin
      state_d     = IDLE_ST;
      idle_cnt_d  = IDLE_LOAD;
      align_cnt_d = '0;
      run_cnt_d   = '0;
      elecidle_d  = 1'b1;
    end else begin
      case (state_q)
        IDLE_ST: begin
          elecidle_d = 1'b1;
          idle_cnt_d = idle_cnt_q - 10'd1;
          if (idle_cnt_q <= 10'd1) begin
            state_d     = ALIGN_ST;
            idle_cnt_d  = '0;
            align_cnt_d = '0;
            elecidle_d  = 1'b0;
          end
        end
        ALIGN_ST: begin
          elecidle_d = 1'b0;
          if (align_cnt_q == ALIGN_LAST) begin
            state_d   = RUN_ST;
            run_cnt_d = '0;
          end else begin
            align_cnt_d = align_cnt_q + 8'd1;
          end
        end
        RUN_ST: begin
          elecidle_d = 1'b0;
          if (xfer) begin
            tx_data_d = frm_data_in;
            tx_kchr_d = frm_kchr_in;
            run_cnt_d = run_cnt_q + RUN_W'(1);
          end else begin
            run_cnt_d = '0;
          end
        end
        default: begin
          state_d     = IDLE_ST;
          idle_cnt_d  = IDLE_LOAD;
          align_cnt_d = '0;
          run_cnt_d   = '0;
          elecidle_d  = 1'b1;
        end
      endcase
    end
  end

  // State and registered transceiver outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE_ST;
      idle_cnt_q  <= IDLE_LOAD;
      align_cnt_q <= '0;
      run_cnt_q   <= '0;
      tx_data_q   <= COMMA_DATA;
      tx_kchr_q   <= COMMA_KCHR;
      elecidle_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      idle_cnt_q  <= idle_cnt_d;
      align_cnt_q <= align_cnt_d;
      run_cnt_q   <= run_cnt_d;
      tx_data_q   <= tx_data_d;
      tx_kchr_q   <= tx_kchr_d;
      elecidle_q  <= elecidle_d;
    end
  end

`ifdef HSSL_TX_FRAME_CNT_EN
  logic [31:0] frames_sent_q, frames_sent_d;

  assign frames_sent_out = frames_sent_q;

  // Accepted-word count; survives restart, wraps naturally.
  always_comb begin
    frames_sent_d = frames_sent_q;
    if (xfer) begin
      frames_sent_d = frames_sent_q + 32'd1;
    end
  end

  // Frame counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frames_sent_q <= '0;
    end else begin
      frames_sent_q <= frames_sent_d;
    end
  end
`endif

endmodule
